// File: rtl/s2p_pkg.sv
// -----------------------------------------------------------------------------
// s2p_pkg
// Shared definitions for the serial2parallel_stream converter:
//   - s2p_order_e   : bit-order selector (which lane the first beat lands in)
//   - s2p_beats     : number of serial beats per output word
//   - s2p_cnt_w     : width of the beat counter, sized to hold 0..BEATS
//   - s2p_params_ok : parameter legality check used at elaboration
// -----------------------------------------------------------------------------
package s2p_pkg;

  typedef enum logic {
    S2P_LSB_FIRST = 1'b0,
    S2P_MSB_FIRST = 1'b1
  } s2p_order_e;

  function automatic int s2p_beats(input int data_w, input int lane_w);
    return (lane_w >= 1) ? (data_w / lane_w) : 1;
  endfunction

  function automatic int s2p_cnt_w(input int data_w, input int lane_w);
    int beats;
    beats = s2p_beats(data_w, lane_w);
    return (beats < 2) ? 1 : $clog2(beats + 1);
  endfunction

  function automatic bit s2p_params_ok(input int data_w, input int lane_w,
                                       input int timeout_cyc);
    return (lane_w >= 1) && (data_w >= lane_w) && ((data_w % lane_w) == 0)
           && (timeout_cyc >= 1);
  endfunction

endpackage

// File: rtl/s2p_lane_shifter.sv
// -----------------------------------------------------------------------------
// s2p_lane_shifter
// Assembles LANE_W-bit beats into a DATA_W-bit word. Holds the shift register,
// the beat counter, flush handling and (optionally) the partial-word timeout.
//
// Build option: define S2P_TIMEOUT_EN to enable the idle timeout. Without it
// there is no idle counter and frame_err_o is constant 0.
//
// Ports:
//   clk, rst        clock / synchronous active-high reset
//   din_i           serial beat data (LANE_W bits)
//   valid_i         beat valid
//   flush_i         discard the partial word (wins over valid_i)
//   word_done_o     combinational strobe: the beat accepted this cycle
//                   completes a word
//   word_o          the word as it will look after this cycle's beat; only
//                   meaningful together with word_done_o
//   beat_cnt_o      beats collected in the current partial word
//   frame_err_o     one-cycle pulse when a partial word times out
// -----------------------------------------------------------------------------
module s2p_lane_shifter
  import s2p_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int LANE_W      = 1,
  parameter int MSB_FIRST   = 1,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [LANE_W-1:0]                     din_i,
  input  logic                                  valid_i,
  input  logic                                  flush_i,
  output logic                                  word_done_o,
  output logic [DATA_W-1:0]                     word_o,
  output logic [s2p_cnt_w(DATA_W, LANE_W)-1:0]  beat_cnt_o,
  output logic                                  frame_err_o
);

  localparam int         BEATS     = s2p_beats(DATA_W, LANE_W);
  localparam int         CNT_W     = s2p_cnt_w(DATA_W, LANE_W);
  localparam bit         PARAMS_OK = s2p_params_ok(DATA_W, LANE_W, TIMEOUT_CYC);
  localparam s2p_order_e ORDER     = (MSB_FIRST != 0) ? S2P_MSB_FIRST : S2P_LSB_FIRST;

  generate
    if (!PARAMS_OK) begin : g_bad_params
      $error("s2p_lane_shifter: DATA_W must be a multiple of LANE_W, LANE_W >= 1, TIMEOUT_CYC >= 1");
    end
  endgenerate

  logic [DATA_W-1:0] shift_q, shift_d, shifted;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              accept, last_beat, timeout;

  // With a single beat per word the incoming beat is the whole word; the
  // general slices below would be empty in that case.
  generate
    if (BEATS == 1) begin : g_single
      assign shifted = din_i;
    end else if (ORDER == S2P_MSB_FIRST) begin : g_msb
      assign shifted = {shift_q[DATA_W-LANE_W-1:0], din_i};
    end else begin : g_lsb
      assign shifted = {din_i, shift_q[DATA_W-1:LANE_W]};
    end
  endgenerate

  assign accept      = valid_i && !flush_i;
  assign last_beat   = (cnt_q == CNT_W'(BEATS - 1));
  assign word_done_o = accept && last_beat;
  assign word_o      = shifted;
  assign beat_cnt_o  = cnt_q;

`ifdef S2P_TIMEOUT_EN
  localparam int IDLE_W = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);

  logic [IDLE_W-1:0] idle_q, idle_d;
  logic              idling;
  logic              frame_err_q;

  // Idle means a partial word exists and nothing (beat or flush) touched it.
  assign idling  = (cnt_q != '0) && !valid_i && !flush_i;
  // Fire on the TIMEOUT_CYC-th consecutive idle cycle.
  assign timeout = idling && (idle_q == IDLE_W'(TIMEOUT_CYC - 1));

  always_comb begin
    idle_d = '0;
    if (idling && !timeout) begin
      idle_d = idle_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idle_q      <= '0;
      frame_err_q <= 1'b0;
    end else begin
      idle_q      <= idle_d;
      frame_err_q <= timeout;
    end
  end

  assign frame_err_o = frame_err_q;
`else
  assign timeout     = 1'b0;
  assign frame_err_o = 1'b0;
`endif

  always_comb begin
    cnt_d   = cnt_q;
    shift_d = shift_q;
    if (flush_i || timeout) begin
      cnt_d   = '0;
      shift_d = '0;
    end else if (accept) begin
      shift_d = shifted;
      cnt_d   = last_beat ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      shift_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
    end
  end

endmodule

// File: rtl/serial2parallel_stream.sv
// -----------------------------------------------------------------------------
// serial2parallel_stream
// Packs LANE_W-bit serial beats into DATA_W-bit words and presents each word
// in an output register under a valid/ready handshake. A word completing
// while the output register is full and not being drained is dropped and
// reported on overflow.
//
// Build option: define S2P_TIMEOUT_EN to discard partial words that sit idle
// for TIMEOUT_CYC cycles (reported on frame_err). Default: disabled.
//
// Ports:
//   clk, rst        clock / synchronous active-high reset
//   din_serial      serial beat data (LANE_W bits)
//   din_valid       beat valid; always accepted
//   flush           discard the partial word being assembled
//   dout_parallel   assembled word (holds its last value while not valid)
//   dout_valid      dout_parallel holds an unconsumed word
//   dout_ready      consumer accepts the word when dout_valid is high
//   overflow        one-cycle pulse when a completed word is dropped
//   beat_cnt        beats collected in the current partial word
//   frame_err       one-cycle partial-word timeout pulse
// -----------------------------------------------------------------------------
module serial2parallel_stream
  import s2p_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int LANE_W      = 1,
  parameter int MSB_FIRST   = 1,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [LANE_W-1:0]                     din_serial,
  input  logic                                  din_valid,
  input  logic                                  flush,
  output logic [DATA_W-1:0]                     dout_parallel,
  output logic                                  dout_valid,
  input  logic                                  dout_ready,
  output logic                                  overflow,
  output logic [s2p_cnt_w(DATA_W, LANE_W)-1:0]  beat_cnt,
  output logic                                  frame_err
);

  logic              word_done;
  logic [DATA_W-1:0] word;

  logic [DATA_W-1:0] dout_q, dout_d;
  logic              valid_q, valid_d;
  logic              ovf_q, ovf_d;
  logic              load;

  s2p_lane_shifter #(
    .DATA_W      (DATA_W),
    .LANE_W      (LANE_W),
    .MSB_FIRST   (MSB_FIRST),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_shifter (
    .clk         (clk),
    .rst         (rst),
    .din_i       (din_serial),
    .valid_i     (din_valid),
    .flush_i     (flush),
    .word_done_o (word_done),
    .word_o      (word),
    .beat_cnt_o  (beat_cnt),
    .frame_err_o (frame_err)
  );

  // The register can take a new word if it is empty or is being drained in
  // this same cycle (back-to-back: valid stays high, word is replaced).
  assign load = word_done && (!valid_q || dout_ready);

  always_comb begin
    dout_d  = dout_q;
    valid_d = valid_q;
    ovf_d   = word_done && valid_q && !dout_ready;
    if (load) begin
      dout_d  = word;
      valid_d = 1'b1;
    end else if (valid_q && dout_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dout_q  <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      dout_q  <= dout_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
    end
  end

  assign dout_parallel = dout_q;
  assign dout_valid    = valid_q;
  assign overflow      = ovf_q;

endmodule

// File: tb/tb_serial2parallel_stream.sv
// -----------------------------------------------------------------------------
// tb_serial2parallel_stream
// Self-checking bench. u_dut: DATA_W=8, LANE_W=1, MSB first, TIMEOUT_CYC=4.
// u_dut2: DATA_W=8, LANE_W=2, LSB first. Honours S2P_TIMEOUT_EN if defined.
// -----------------------------------------------------------------------------
module tb_serial2parallel_stream;

`ifdef S2P_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DUT 1 signals
  logic       rst, dv, fl, rdy;
  logic [0:0] din;
  logic [7:0] dout;
  logic       dvld, ovf, ferr;
  logic [3:0] bcnt;

  // DUT 2 signals
  logic       rst2, dv2, fl2, rdy2;
  logic [1:0] din2;
  logic [7:0] dout2;
  logic       dvld2, ovf2, ferr2;
  logic [2:0] bcnt2;

  serial2parallel_stream #(
    .DATA_W(8), .LANE_W(1), .MSB_FIRST(1), .TIMEOUT_CYC(4)
  ) u_dut (
    .clk(clk), .rst(rst), .din_serial(din), .din_valid(dv), .flush(fl),
    .dout_parallel(dout), .dout_valid(dvld), .dout_ready(rdy),
    .overflow(ovf), .beat_cnt(bcnt), .frame_err(ferr)
  );

  serial2parallel_stream #(
    .DATA_W(8), .LANE_W(2), .MSB_FIRST(0), .TIMEOUT_CYC(16)
  ) u_dut2 (
    .clk(clk), .rst(rst2), .din_serial(din2), .din_valid(dv2), .flush(fl2),
    .dout_parallel(dout2), .dout_valid(dvld2), .dout_ready(rdy2),
    .overflow(ovf2), .beat_cnt(bcnt2), .frame_err(ferr2)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference model for u_dut: a queue of received bits, and the word
  // offered to the consumer.
  bit         q[$];
  bit         m_valid;
  logic [7:0] m_data;
  bit         m_ovf, m_ferr;
  int         m_idle;

  task automatic model_step(input bit r, input bit v, input bit d, input bit f, input bit rd);
    int word;
    bit done;
    if (r) begin
      q.delete(); m_valid = 0; m_data = 8'h00; m_ovf = 0; m_ferr = 0; m_idle = 0;
      return;
    end
    m_ovf = 0; m_ferr = 0; done = 0; word = 0;
    if (f) begin
      q.delete(); m_idle = 0;
    end else if (v) begin
      q.push_back(d); m_idle = 0;
      if (q.size() == 8) begin
        for (int i = 0; i < 8; i++) word = word * 2 + int'(q[i]);
        q.delete();
        done = 1;
      end
    end else if (q.size() > 0) begin
      if (TMO_EN) begin
        m_idle++;
        if (m_idle == 4) begin
          q.delete(); m_idle = 0; m_ferr = 1;
        end
      end
    end else begin
      m_idle = 0;
    end
    if (done) begin
      if (!m_valid || rd) begin
        m_valid = 1; m_data = word[7:0];
      end else begin
        m_ovf = 1;
      end
    end else if (m_valid && rd) begin
      m_valid = 0;
    end
  endtask

  task automatic compare_all();
    check("dout_valid", 32'(dvld), 32'(m_valid));
    check("dout_parallel", 32'(dout), 32'(m_data));
    check("overflow", 32'(ovf), 32'(m_ovf));
    check("beat_cnt", 32'(bcnt), 32'(q.size()));
    check("frame_err", 32'(ferr), 32'(m_ferr));
  endtask

  task automatic cycle(input bit r, input bit v, input bit d, input bit f, input bit rd);
    rst = r; dv = v; din = d; fl = f; rdy = rd;
    @(posedge clk);
    model_step(r, v, d, f, rd);
    #1;
    $display("cyc rst=%0b v=%0b d=%0b fl=%0b rdy=%0b -> dout=%02h dvld=%0b ovf=%0b cnt=%0d ferr=%0b",
             r, v, d, f, rd, dout, dvld, ovf, bcnt, ferr);
    compare_all();
  endtask

  task automatic send_word(input logic [7:0] w, input bit rd_last);
    for (int i = 7; i >= 0; i--) cycle(0, 1, w[i], 0, (i == 0) ? rd_last : 1'b0);
  endtask

  task automatic cycle2(input bit r, input bit v, input logic [1:0] d, input bit rd);
    rst2 = r; dv2 = v; din2 = d; fl2 = 1'b0; rdy2 = rd;
    @(posedge clk);
    #1;
    $display("dut2 rst=%0b v=%0b d=%02b -> dout=%02h dvld=%0b cnt=%0d",
             r, v, d, dout2, dvld2, bcnt2);
  endtask

  typedef struct {
    bit         v;
    bit         d;
    bit         rd;
    bit         ev;
    logic [7:0] ed;
    logic [3:0] ec;
    bit         eo;
  } vec_t;

  vec_t tbl[11];

  initial begin
    // Directed table: beats 1,0,1,1,0,0,1,0 -> 8'hB2, then consume.
    tbl[0]  = '{1, 1, 0, 0, 8'h00, 4'd1, 0};
    tbl[1]  = '{1, 0, 0, 0, 8'h00, 4'd2, 0};
    tbl[2]  = '{1, 1, 0, 0, 8'h00, 4'd3, 0};
    tbl[3]  = '{1, 1, 0, 0, 8'h00, 4'd4, 0};
    tbl[4]  = '{1, 0, 0, 0, 8'h00, 4'd5, 0};
    tbl[5]  = '{1, 0, 0, 0, 8'h00, 4'd6, 0};
    tbl[6]  = '{1, 1, 0, 0, 8'h00, 4'd7, 0};
    tbl[7]  = '{1, 0, 0, 1, 8'hB2, 4'd0, 0};
    tbl[8]  = '{0, 0, 0, 1, 8'hB2, 4'd0, 0};
    tbl[9]  = '{0, 0, 1, 0, 8'hB2, 4'd0, 0};
    tbl[10] = '{0, 0, 0, 0, 8'hB2, 4'd0, 0};

    rst = 1; dv = 0; din = '0; fl = 0; rdy = 0;
    rst2 = 1; dv2 = 0; din2 = '0; fl2 = 0; rdy2 = 0;

    // Reset state
    cycle(1, 0, 0, 0, 0);
    cycle(1, 1, 1, 0, 1);
    check("reset dout_valid", 32'(dvld), 32'd0);
    check("reset beat_cnt", 32'(bcnt), 32'd0);

    // Table-driven vectors
    for (int i = 0; i < 11; i++) begin
      rst = 0; dv = tbl[i].v; din = tbl[i].d; fl = 0; rdy = tbl[i].rd;
      @(posedge clk);
      model_step(0, tbl[i].v, tbl[i].d, 0, tbl[i].rd);
      #1;
      $display("vec %0d v=%0b d=%0b rdy=%0b -> dout=%02h dvld=%0b cnt=%0d ovf=%0b",
               i, tbl[i].v, tbl[i].d, tbl[i].rd, dout, dvld, bcnt, ovf);
      check("tbl dout_valid", 32'(dvld), 32'(tbl[i].ev));
      check("tbl dout_parallel", 32'(dout), 32'(tbl[i].ed));
      check("tbl beat_cnt", 32'(bcnt), 32'(tbl[i].ec));
      check("tbl overflow", 32'(ovf), 32'(tbl[i].eo));
    end

    // Overflow: second word completes while the first is still unconsumed.
    send_word(8'hA5, 0);
    check("first word", 32'(dout), 32'hA5);
    send_word(8'h3C, 0);
    check("overflow pulse", 32'(ovf), 32'd1);
    check("overflow retains old", 32'(dout), 32'hA5);
    check("overflow cnt wraps", 32'(bcnt), 32'd0);
    cycle(0, 0, 0, 0, 0);
    check("overflow one cycle", 32'(ovf), 32'd0);
    // Back-to-back: ready high in the completion cycle.
    send_word(8'h5A, 1);
    check("b2b valid stays", 32'(dvld), 32'd1);
    check("b2b new word", 32'(dout), 32'h5A);
    check("b2b no overflow", 32'(ovf), 32'd0);
    cycle(0, 0, 0, 0, 1);
    check("drain", 32'(dvld), 32'd0);

    // Gap tolerance: 3 beats, 5 idle, 5 beats of 8'hC6.
    cycle(0, 1, 1, 0, 0); cycle(0, 1, 1, 0, 0); cycle(0, 1, 0, 0, 0);
    for (int i = 0; i < 5; i++) cycle(0, 0, 0, 0, 0);
    check("gap cnt", 32'(bcnt), TMO_EN ? 32'd0 : 32'd3);
    cycle(0, 1, 0, 0, 0); cycle(0, 1, 0, 0, 0); cycle(0, 1, 1, 0, 0);
    cycle(0, 1, 1, 0, 0); cycle(0, 1, 0, 0, 0);
    check("gap word valid", 32'(dvld), TMO_EN ? 32'd0 : 32'd1);
    check("gap word", 32'(dout), TMO_EN ? 32'h5A : 32'hC6);

    // Flush with a coincident valid beat.
    cycle(0, 0, 0, 1, 1);
    cycle(0, 1, 1, 0, 0); cycle(0, 1, 0, 0, 0); cycle(0, 1, 1, 0, 0);
    cycle(0, 1, 1, 1, 0);
    check("flush cnt", 32'(bcnt), 32'd0);
    send_word(8'h96, 0);
    check("post-flush word", 32'(dout), 32'h96);

    // Reset mid-word while dout_valid is high.
    for (int i = 0; i < 5; i++) cycle(0, 1, 1, 0, 0);
    cycle(1, 1, 1, 0, 0);
    check("rst dout_valid", 32'(dvld), 32'd0);
    check("rst dout_parallel", 32'(dout), 32'd0);
    check("rst beat_cnt", 32'(bcnt), 32'd0);
    send_word(8'h4D, 0);
    check("post-rst word", 32'(dout), 32'h4D);

    // Timeout: 2 beats then 4 idle cycles.
    cycle(0, 0, 0, 1, 1);
    cycle(0, 1, 1, 0, 0); cycle(0, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0, 0);
    check("timeout frame_err", 32'(ferr), 32'(TMO_EN));
    check("timeout beat_cnt", 32'(bcnt), TMO_EN ? 32'd0 : 32'd2);
    cycle(0, 0, 0, 0, 0);
    check("frame_err one cycle", 32'(ferr), 32'd0);

    // Randomized run against the model.
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(0, 99) == 0), ($urandom_range(0, 9) < 7),
            1'($urandom_range(0, 1)), ($urandom_range(0, 24) == 0),
            1'($urandom_range(0, 1)));
    end

    // DUT 2: LANE_W=2, LSB first: 01,10,11,00 -> 8'h39.
    cycle2(1, 0, 2'b00, 0);
    cycle2(0, 1, 2'b01, 0);
    check("dut2 cnt1", 32'(bcnt2), 32'd1);
    cycle2(0, 1, 2'b10, 0);
    check("dut2 cnt2", 32'(bcnt2), 32'd2);
    cycle2(0, 1, 2'b11, 0);
    check("dut2 cnt3", 32'(bcnt2), 32'd3);
    cycle2(0, 1, 2'b00, 0);
    check("dut2 word", 32'(dout2), 32'h39);
    check("dut2 valid", 32'(dvld2), 32'd1);
    check("dut2 cnt wrap", 32'(bcnt2), 32'd0);
    check("dut2 ovf", 32'(ovf2), 32'd0);
    check("dut2 frame_err", 32'(ferr2), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/serial2parallel_stream.md
Name: serial2parallel_stream

Overview:
- Parametrised successor to the single-bit serial-to-parallel converter.
- Packs LANE_W-bit serial beats into DATA_W-bit words, with selectable bit order.
- Holds each completed word in an output register under a valid/ready handshake; detects overflow; supports flush of a partial word.
- Sits between serial front-end receivers and word-wide datapath consumers.

Parameters:
- DATA_W, 8, output word width; must be a multiple of LANE_W.
- LANE_W, 1, serial bits accepted per valid beat.
- MSB_FIRST, 1, 1 = first beat lands in the most-significant lane; 0 = first beat lands in the least-significant lane.
- TIMEOUT_CYC, 16, idle-cycle limit for a partial word; used only with S2P_TIMEOUT_EN.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- din_serial  in  LANE_W  serial beat data.
- din_valid  in  1  beat is valid this cycle; always accepted, no backpressure.
- flush  in  1  discard the partial word being assembled.
- dout_parallel  out  DATA_W  assembled word.
- dout_valid  out  1  dout_parallel holds an unconsumed word.
- dout_ready  in  1  consumer accepts the word when dout_valid is also high.
- overflow  out  1  one-cycle pulse when a completed word is dropped.
- beat_cnt  out  clog2(BEATS+1)  beats collected in the current partial word.
- frame_err  out  1  one-cycle timeout pulse; tied to 0 without S2P_TIMEOUT_EN.

Behaviour:
- BEATS = DATA_W/LANE_W.
- Reset (rst=1 at an edge): all outputs go to 0, the shift register clears, and beat_cnt = 0. Reset overrides every other input, including mid-word and while dout_valid is high; any pending word is lost.
- Accepted beat (din_valid=1, flush=0):
  - MSB_FIRST=1: shift_reg <= {shift_reg[DATA_W-LANE_W-1:0], din_serial}.
  - MSB_FIRST=0: shift_reg <= {din_serial, shift_reg[DATA_W-1:LANE_W]}.
  - beat_cnt increments.
- Gaps (din_valid=0): beat_cnt and shift_reg hold. Gaps never reset the count.
- Completion: the beat accepted with beat_cnt = BEATS-1 completes the word.
  - Same edge: beat_cnt wraps to 0.
  - The completed word is offered to the output register in that same edge.
  - dout_valid rises the cycle after the final beat: 1-cycle latency.
- Output register:
  - Loads when dout_valid=0, or when dout_valid=1 and dout_ready=1 in the completion cycle. The second case is a back-to-back load: dout_valid stays 1 and the new word replaces the old.
  - When dout_valid=1, dout_ready=1, and no completion: dout_valid clears next cycle.
  - dout_parallel holds its last value when dout_valid=0.
- Overflow: completion while dout_valid=1 and dout_ready=0.
  - The new word is discarded and the old word is retained.
  - overflow pulses for 1 cycle.
  - The beat count still wraps to 0.
- Flush:
  - Clears shift_reg and beat_cnt next cycle; the output register is unaffected.
  - flush together with din_valid: flush wins and the beat is discarded, including a would-be completing beat.
- DATA_W == LANE_W: every beat is a complete word, and beat_cnt stays 0.

Optional Feature:
- Macro S2P_TIMEOUT_EN.
- Defined:
  - An idle counter runs while beat_cnt != 0 and din_valid=0, and clears on any beat.
  - When it reaches TIMEOUT_CYC, the partial word is discarded as if flushed and frame_err pulses for 1 cycle.
  - The counter does not run when beat_cnt = 0.
- Undefined: no idle counter exists, frame_err is constant 0, and partial words wait indefinitely.

Decomposition:
- Package s2p_pkg holds:
  - the function computing BEATS and the beat_cnt width;
  - a localparam check that DATA_W % LANE_W == 0 and LANE_W >= 1;
  - an enum for bit order (S2P_MSB_FIRST, S2P_LSB_FIRST).
- Sub-module s2p_lane_shifter contains the shift register, beat counter, flush and timeout logic, and outputs a word_done strobe plus the word.
- The top level owns the output register, the handshake, and overflow.

Test Plan:
- DATA_W=8, LANE_W=1, MSB_FIRST=1: beats 1,0,1,1,0,0,1,0 -> dout_parallel=8'hB2 and dout_valid=1 the cycle after beat 8.
- DATA_W=8, LANE_W=2, MSB_FIRST=0: beats 2'b01,2'b10,2'b11,2'b00 -> dout_parallel=8'h39 after 4 beats, and beat_cnt back to 0.
- First word done with dout_ready=0, then 8 more beats -> overflow pulses 1 cycle and the first word is retained. Repeat with dout_ready=1 at the second completion -> dout_valid stays 1 and the second word appears.
- 3 beats, 5 idle cycles, 5 beats -> one complete word, with the gap tolerated. 3 beats then flush with din_valid=1 -> beat_cnt=0 and the next 8 beats form a clean word.
- rst asserted for 1 cycle after beat 5 while dout_valid=1 -> all outputs 0 next cycle, and the following 8 beats produce a correct word.
- S2P_TIMEOUT_EN, TIMEOUT_CYC=4: 2 beats then 4 idle cycles -> frame_err pulses once and beat_cnt=0; without the macro, frame_err stays 0 and beat_cnt stays 2.
